// File: rtl/square_tone_gen_if.sv
// Codec write channel: one stereo sample per write/write_ready handshake,
// plus a wrap pulse marking acceptance of the last sample of a tone period.
interface square_tone_gen_if #(
    parameter int SAMPLE_W = 24
);
    logic                write;
    logic                write_ready;
    logic [SAMPLE_W-1:0] writedata_left;
    logic [SAMPLE_W-1:0] writedata_right;
    logic                wrap;

    modport master (
        output write, writedata_left, writedata_right, wrap,
        input  write_ready
    );

    modport slave (
        input  write, writedata_left, writedata_right, wrap,
        output write_ready
    );
endinterface

// File: rtl/square_tone_gen.sv
// Square-wave tone generator: turns a period (in samples) into a stream of
// +/-AMPLITUDE stereo samples delivered through the codec write handshake.
module square_tone_gen #(
    parameter int                          PERIOD_W  = 24,
    parameter int                          SAMPLE_W  = 24,
    parameter logic signed [SAMPLE_W-1:0]  AMPLITUDE = 24'sd2000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    square_tone_gen_if.master   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [SAMPLE_W-1:0] POS_SAMPLE = AMPLITUDE;
    localparam logic [SAMPLE_W-1:0] NEG_SAMPLE = SAMPLE_W'(-AMPLITUDE);

    state_t              state, state_n;
    logic [PERIOD_W-1:0] cnt, cnt_n;
    logic [PERIOD_W-1:0] p_lat, p_lat_n;
    logic                write_q, write_n;
    logic [SAMPLE_W-1:0] data_q, data_n;
    logic                wrap_q, wrap_n;

    // Periods below 2 cannot hold both a high and a low sample.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(2)) ? PERIOD_W'(2) : p;
    endfunction

    // High phase covers the first p>>1 samples; odd periods spend the extra one low.
    function automatic logic [SAMPLE_W-1:0] sample_for(input logic [PERIOD_W-1:0] c,
                                                       input logic [PERIOD_W-1:0] p);
        return (c < (p >> 1)) ? POS_SAMPLE : NEG_SAMPLE;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_lat_n = p_lat;
        write_n = write_q;
        data_n  = data_q;
        wrap_n  = 1'b0;

        case (state)
            IDLE: begin
                write_n = 1'b0;
                data_n  = '0;
                if (enable) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                    p_lat_n = clamp_period(period);
                    write_n = 1'b1;
                    data_n  = sample_for(PERIOD_W'(0), p_lat_n);
                end
            end
            DRIVE: begin
                // Outputs are only allowed to move on an accept; a stall holds everything.
                if (bus.write_ready) begin
                    if (cnt == p_lat - PERIOD_W'(1)) begin
                        cnt_n   = '0;
                        p_lat_n = clamp_period(period);
                        wrap_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + PERIOD_W'(1);
                    end

                    if (enable) begin
                        data_n = sample_for(cnt_n, p_lat_n);
                    end else begin
                        state_n = IDLE;
                        write_n = 1'b0;
                        data_n  = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            p_lat   <= PERIOD_W'(2);
            write_q <= 1'b0;
            data_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            p_lat   <= p_lat_n;
            write_q <= write_n;
            data_q  <= data_n;
            wrap_q  <= wrap_n;
        end
    end

    assign bus.write           = write_q;
    assign bus.writedata_left  = data_q;
    assign bus.writedata_right = data_q;
    assign bus.wrap            = wrap_q;

endmodule

// File: tb/tb_square_tone_gen.sv
// Bench for square_tone_gen: a sample-stream model checked every cycle, plus
// literal accepted-sample sequences for each directed scenario.
module tb_square_tone_gen;

    localparam int PW = 24;
    localparam int SW = 24;
    localparam logic signed [SW-1:0] AMP = 24'sd2000000;
    localparam logic [SW-1:0] PA = AMP;
    localparam logic [SW-1:0] NA = SW'(-AMP);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] period = PW'(8);

    square_tone_gen_if #(.SAMPLE_W(SW)) bus ();

    square_tone_gen #(
        .PERIOD_W (PW),
        .SAMPLE_W (SW),
        .AMPLITUDE(AMP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .period(period),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Stream model: position within the current period and the period in force.
    bit             m_on   = 1'b0;
    bit             m_wrap = 1'b0;
    int             m_pos  = 0;
    int             m_per  = 2;
    logic [SW-1:0]  acc[$];
    int             wraps_seen = 0;

    function automatic int clamp(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic logic [SW-1:0] model_data();
        if (!m_on) return '0;
        return (m_pos < m_per / 2) ? PA : NA;
    endfunction

    always begin
        @(posedge clk);
        if (reset && bus.write && bus.write_ready) acc.push_back(bus.writedata_left);
        if (!reset) begin
            m_on = 1'b0; m_wrap = 1'b0; m_pos = 0; m_per = 2;
        end else if (!m_on) begin
            m_wrap = 1'b0;
            if (enable) begin
                m_on = 1'b1; m_pos = 0; m_per = clamp(int'(period));
            end
        end else begin
            m_wrap = 1'b0;
            if (bus.write_ready) begin
                m_pos++;
                if (m_pos == m_per) begin
                    m_pos = 0; m_per = clamp(int'(period)); m_wrap = 1'b1;
                end
                if (!enable) m_on = 1'b0;
            end
        end
        #1;
        if (reset) begin
            check("write", bus.write, m_on);
            check("data_left", bus.writedata_left, model_data());
            check("data_right", bus.writedata_right, model_data());
            check("wrap", bus.wrap, m_wrap);
            if (bus.wrap) wraps_seen++;
        end
    end

    task automatic wait_acc(input int n, input int budget);
        int c = 0;
        while (acc.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("accept_budget", acc.size() >= n, 1'b1);
    endtask

    // Compare accepted samples against a literal high/low pattern.
    task automatic check_pat(input string name, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            if (i < acc.size())
                check(name, acc[i], (pat[i] == "+") ? PA : NA);
            else
                check(name, 64'hdead, (pat[i] == "+") ? PA : NA);
        end
    endtask

    task automatic restart(input int p);
        @(negedge clk);
        enable = 1'b0;
        bus.write_ready = 1'b1;
        repeat (3) @(negedge clk);
        acc.delete();
        wraps_seen = 0;
        period = PW'(p);
        enable = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.write_ready = 1'b1;

        // Reset, then idle with enable low.
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("reset_write", bus.write, 1'b0);
        check("reset_data", bus.writedata_left, '0);
        check("reset_wrap", bus.wrap, 1'b0);
        repeat (20) @(negedge clk);

        // Continuous accept, period 8; write rises one cycle after enable.
        acc.delete();
        wraps_seen = 0;
        enable = 1'b1;
        check("start_write_low", bus.write, 1'b0);
        @(posedge clk); #1;
        check("start_write_high", bus.write, 1'b1);
        check("start_data", bus.writedata_left, PA);
        wait_acc(16, 40);
        check_pat("cont_p8", "++++----++++----");
        check("cont_wraps", wraps_seen, 2);

        // One-in-three ready: same sequence, stalls held.
        restart(8);
        for (int k = 0; k < 200 && acc.size() < 16; k++) begin
            @(negedge clk);
            bus.write_ready = (k % 3 == 0);
        end
        check_pat("stall_p8", "++++----++++----");
        check("stall_wraps", wraps_seen, 2);

        // Period change mid-period takes effect only after the wrap.
        restart(8);
        wait_acc(3, 20);
        period = PW'(16);
        wait_acc(24, 40);
        check_pat("p8_to_p16", "++++----++++++++--------");

        // Odd and clamped periods.
        restart(5);
        wait_acc(10, 30);
        check_pat("p5", "++---++---");
        check("p5_wraps", wraps_seen, 2);
        restart(1);
        wait_acc(4, 20);
        check_pat("p1", "+-+-");
        check("p1_wraps", wraps_seen, 2);
        restart(0);
        wait_acc(4, 20);
        check_pat("p0", "+-+-");
        check("p0_wraps", wraps_seen, 2);

        // Enable dropped during a stall: pending sample held, accepted, then idle.
        restart(8);
        wait_acc(2, 20);
        bus.write_ready = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("held_write", bus.write, 1'b1);
        check("held_data", bus.writedata_left, PA);
        bus.write_ready = 1'b1;
        @(posedge clk); #1;
        check("drop_write", bus.write, 1'b0);
        check("drop_accepts", acc.size(), 3);
        @(negedge clk);
        acc.delete();
        enable = 1'b1;
        wait_acc(4, 20);
        check_pat("reenable", "++++");

        // Asynchronous reset between clock edges during a stall.
        @(negedge clk);
        bus.write_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_write", bus.write, 1'b0);
        check("async_data", bus.writedata_left, '0);
        check("async_wrap", bus.wrap, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        bus.write_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", bus.write, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
